// File: rtl/puf_soc_ro_challenge_seq_pkg.sv
// Shared types and timing constants for the RO-PUF challenge sequencer.
package puf_soc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_EVAL  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_CMP   = 3'd4,
    ST_DONE  = 3'd5
  } ro_seq_state_t;

  // Cycles the decoder stays disabled after a window before the counts are compared.
  localparam int HOLD_CYCLES = 2;
  // SETUP + HOLD + CMP cycles added to every evaluation window.
  localparam int PAIR_OVERHEAD = 4;

endpackage

// File: rtl/puf_soc_ro_challenge_seq_if.sv
// Bundle between the SoC control side, the RO decoder/counter fabric and the sequencer.
interface puf_soc_ro_challenge_seq_if
  import puf_soc_pkg::*;
#(
  parameter int MUX_LENGTH = 16,
  parameter int N_PAIRS    = MUX_LENGTH / 2,
  parameter int CNT_W      = 16
) ();
  localparam int SEL_W = $clog2(MUX_LENGTH);
  localparam int TIE_W = $clog2(N_PAIRS + 1);

  // i_start is a request sampled only while idle; a request seen while busy is dropped, never queued.
  // o_resp_valid is a single-cycle pulse with no ready; o_resp/o_tie_cnt hold until the next accepted start.
  logic               i_start;
  logic [SEL_W-1:0]   i_chal_seed;
  logic [CNT_W-1:0]   i_cnt_a;
  logic [CNT_W-1:0]   i_cnt_b;
  logic               o_cnt_clr;
  logic               o_dcod_en;
  logic [SEL_W-1:0]   o_sel_mux_0;
  logic [SEL_W-1:0]   o_sel_mux_1;
  logic               o_busy;
  logic [N_PAIRS-1:0] o_resp;
  logic               o_resp_valid;
  logic [TIE_W-1:0]   o_tie_cnt;
  ro_seq_state_t      dbg_state;

  modport master (
    input  i_start, i_chal_seed, i_cnt_a, i_cnt_b,
    output o_cnt_clr, o_dcod_en, o_sel_mux_0, o_sel_mux_1,
    output o_busy, o_resp, o_resp_valid, o_tie_cnt, dbg_state
  );

  modport slave (
    output i_start, i_chal_seed, i_cnt_a, i_cnt_b,
    input  o_cnt_clr, o_dcod_en, o_sel_mux_0, o_sel_mux_1,
    input  o_busy, o_resp, o_resp_valid, o_tie_cnt, dbg_state
  );

endinterface

// File: rtl/puf_soc_ro_win_timer.sv
// Loadable down-counter timing one evaluation window; o_tc marks its last cycle.
module puf_soc_ro_win_timer #(
  parameter int EVAL_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_en,
  output logic o_tc
);
  localparam int TW = (EVAL_CYCLES > 1) ? $clog2(EVAL_CYCLES) : 1;

  logic [TW-1:0] count_q;
  logic [TW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (i_load) begin
      count_d = TW'(EVAL_CYCLES - 1);
    end else if (i_en && (count_q != '0)) begin
      count_d = count_q - TW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_tc = i_en && (count_q == '0);

endmodule

// File: rtl/puf_soc_ro_challenge_seq.sv
// Walks the RO pairs of one challenge, times each window and builds the response word.
module puf_soc_ro_challenge_seq
  import puf_soc_pkg::*;
#(
  parameter int MUX_LENGTH  = 16,
  parameter int N_PAIRS     = MUX_LENGTH / 2,
  parameter int EVAL_CYCLES = 1024,
  parameter int CNT_W       = 16
) (
  input logic                        clk,
  input logic                        rst,
  puf_soc_ro_challenge_seq_if.master bus
);
  localparam int SEL_W  = $clog2(MUX_LENGTH);
  localparam int K_W    = (N_PAIRS > 1) ? $clog2(N_PAIRS) : 1;
  localparam int TIE_W  = $clog2(N_PAIRS + 1);
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [SEL_W-1:0]  HALF   = SEL_W'(MUX_LENGTH / 2);
  localparam logic [K_W-1:0]    K_LAST = K_W'(N_PAIRS - 1);
  localparam logic [HOLD_W-1:0] H_LAST = HOLD_W'(HOLD_CYCLES - 1);

  ro_seq_state_t      state_q, state_d;
  logic [SEL_W-1:0]   seed_q, seed_d;
  logic [K_W-1:0]     k_q, k_d;
  logic [SEL_W-1:0]   sel0_q, sel0_d;
  logic [SEL_W-1:0]   sel1_q, sel1_d;
  logic [N_PAIRS-1:0] resp_q, resp_d;
  logic [TIE_W-1:0]   tie_q, tie_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               timer_load;
  logic               timer_en;
  logic               timer_tc;

  puf_soc_ro_win_timer #(
    .EVAL_CYCLES (EVAL_CYCLES)
  ) u_win_timer (
    .clk    (clk),
    .rst    (rst),
    .i_load (timer_load),
    .i_en   (timer_en),
    .o_tc   (timer_tc)
  );

  always_comb begin
    state_d    = state_q;
    seed_d     = seed_q;
    k_d        = k_q;
    sel0_d     = sel0_q;
    sel1_d     = sel1_q;
    resp_d     = resp_q;
    tie_d      = tie_q;
    hold_d     = hold_q;
    timer_load = 1'b0;
    timer_en   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.i_start) begin
          seed_d  = bus.i_chal_seed;
          k_d     = '0;
          resp_d  = '0;
          tie_d   = '0;
          sel0_d  = bus.i_chal_seed;
          sel1_d  = bus.i_chal_seed + HALF;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        timer_load = 1'b1;
        state_d    = ST_EVAL;
      end
      ST_EVAL: begin
        timer_en = 1'b1;
        if (timer_tc) begin
          hold_d  = '0;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        hold_d = hold_q + HOLD_W'(1);
        if (hold_q == H_LAST) begin
          state_d = ST_CMP;
        end
      end
      ST_CMP: begin
        // Ties resolve to 0 and are tallied separately so software can judge bit quality.
        resp_d[k_q] = (bus.i_cnt_a > bus.i_cnt_b);
        if (bus.i_cnt_a == bus.i_cnt_b) begin
          tie_d = tie_q + TIE_W'(1);
        end
        if (k_q == K_LAST) begin
          state_d = ST_DONE;
        end else begin
          k_d     = k_q + K_W'(1);
          sel0_d  = seed_q + SEL_W'(k_q + K_W'(1));
          sel1_d  = seed_q + SEL_W'(k_q + K_W'(1)) + HALF;
          state_d = ST_SETUP;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      seed_q  <= '0;
      k_q     <= '0;
      sel0_q  <= '0;
      sel1_q  <= '0;
      resp_q  <= '0;
      tie_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      seed_q  <= seed_d;
      k_q     <= k_d;
      sel0_q  <= sel0_d;
      sel1_q  <= sel1_d;
      resp_q  <= resp_d;
      tie_q   <= tie_d;
      hold_q  <= hold_d;
    end
  end

  // Enable decodes straight from the state flop so reset removes it without waiting for a clock.
  assign bus.o_dcod_en    = (state_q == ST_EVAL);
  assign bus.o_cnt_clr    = (state_q == ST_SETUP);
  assign bus.o_busy       = (state_q != ST_IDLE);
  assign bus.o_resp_valid = (state_q == ST_DONE);
  assign bus.o_sel_mux_0  = sel0_q;
  assign bus.o_sel_mux_1  = sel1_q;
  assign bus.o_resp       = resp_q;
  assign bus.o_tie_cnt    = tie_q;
  assign bus.dbg_state    = state_q;

endmodule

// File: tb/tb_puf_soc_ro_challenge_seq.sv
// Randomised bench for the RO-PUF challenge sequencer against a timeline/response model.
module tb_puf_soc_ro_challenge_seq;
  localparam int MUX_LENGTH  = 16;
  localparam int N_PAIRS     = 8;
  localparam int EVAL_CYCLES = 8;
  localparam int CNT_W       = 16;
  localparam int PAIR_CYC    = EVAL_CYCLES + 4;
  localparam int RUN_CYC     = N_PAIRS * PAIR_CYC + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  puf_soc_ro_challenge_seq_if #(
    .MUX_LENGTH (MUX_LENGTH),
    .N_PAIRS    (N_PAIRS),
    .CNT_W      (CNT_W)
  ) bus ();

  puf_soc_ro_challenge_seq #(
    .MUX_LENGTH  (MUX_LENGTH),
    .N_PAIRS     (N_PAIRS),
    .EVAL_CYCLES (EVAL_CYCLES),
    .CNT_W       (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [15:0] ro_val [16];
  int          cur_mode = 0;
  int          m_mode = 0;
  logic [3:0]  m_seed = '0;
  logic        m_active = 1'b0;
  int          m_rel = 0;
  logic [7:0]  m_exp_resp = '0;
  logic [3:0]  m_exp_tie = '0;
  logic        m_have = 1'b0;
  int          valid_pulses = 0;
  int          en_run = 0;
  logic        prev_en = 1'b0;
  logic        prev_clr = 1'b0;
  logic [7:0]  prev_sel = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // RO fabric stand-in: counts seen for the selected pair under each stimulus mode.
  function automatic logic [31:0] fab(input int mode, input logic [3:0] seed,
                                      input logic [3:0] s0, input logic [3:0] s1);
    logic [3:0] k;
    k = s0 - seed;
    case (mode)
      1: return {16'd100, 16'd50};
      2: return {(s0[0] ? 16'd10 : 16'd20), 16'd15};
      3: return ((k == 4'd2) || (k == 4'd5)) ? {16'd77, 16'd77} : {16'd10, 16'd30};
      default: return {ro_val[s0], ro_val[s1]};
    endcase
  endfunction

  function automatic logic [11:0] model_result(input logic [3:0] seed, input int mode);
    logic [7:0]  r;
    logic [3:0]  t;
    logic [3:0]  s0;
    logic [31:0] ab;
    r = '0;
    t = '0;
    for (int k = 0; k < N_PAIRS; k++) begin
      s0 = seed + 4'(k);
      ab = fab(mode, seed, s0, s0 + 4'd8);
      if (ab[31:16] > ab[15:0])  r[k] = 1'b1;
      if (ab[31:16] == ab[15:0]) t = t + 4'd1;
    end
    return {t, r};
  endfunction

  // {busy, cnt_clr, dcod_en, resp_valid} for relative cycle rel after the accepting edge.
  function automatic logic [3:0] exp_ctrl(input logic active, input int rel);
    int phase;
    if (!active) return 4'b0000;
    if (rel == RUN_CYC) return 4'b1001;
    phase = (rel - 1) % PAIR_CYC;
    return {1'b1, (phase == 0), (phase >= 1 && phase <= EVAL_CYCLES), 1'b0};
  endfunction

  function automatic logic [7:0] exp_sel(input logic [3:0] seed, input int rel);
    logic [3:0] s0;
    s0 = seed + 4'((rel - 1) / PAIR_CYC);
    return {s0, s0 + 4'd8};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active <= 1'b0;
      m_rel    <= 0;
      m_have   <= 1'b0;
    end else if (!m_active) begin
      if (bus.i_start) begin
        m_active <= 1'b1;
        m_rel    <= 1;
        m_seed   <= bus.i_chal_seed;
        m_mode   <= cur_mode;
        {m_exp_tie, m_exp_resp} <= model_result(bus.i_chal_seed, cur_mode);
        m_have   <= 1'b0;
      end
    end else if (m_rel == RUN_CYC) begin
      m_active <= 1'b0;
      m_rel    <= 0;
      m_have   <= 1'b1;
    end else begin
      m_rel <= m_rel + 1;
    end
  end

  always @(negedge clk) begin
    {bus.i_cnt_a, bus.i_cnt_b} <= fab(m_mode, m_seed, bus.o_sel_mux_0, bus.o_sel_mux_1);
  end

  always @(negedge clk) begin
    if (rst) begin
      en_run   <= 0;
      prev_en  <= 1'b0;
      prev_clr <= 1'b0;
    end else begin
      chk("ctrl", 32'({bus.o_busy, bus.o_cnt_clr, bus.o_dcod_en, bus.o_resp_valid}),
          32'(exp_ctrl(m_active, m_rel)));
      if (m_active && m_rel != RUN_CYC)
        chk("sel", 32'({bus.o_sel_mux_0, bus.o_sel_mux_1}), 32'(exp_sel(m_seed, m_rel)));
      if (m_active && m_rel == RUN_CYC)
        chk("resp_done", 32'({bus.o_tie_cnt, bus.o_resp}), 32'({m_exp_tie, m_exp_resp}));
      else if (!m_active)
        chk("resp_idle", 32'({bus.o_tie_cnt, bus.o_resp}),
            m_have ? 32'({m_exp_tie, m_exp_resp}) : 32'd0);
      if (bus.o_dcod_en) begin
        en_run <= en_run + 1;
      end else if (en_run != 0) begin
        chk("en_len", 32'(en_run), 32'(EVAL_CYCLES));
        en_run <= 0;
      end
      if (bus.o_dcod_en && prev_en)
        chk("sel_stable", 32'({bus.o_sel_mux_0, bus.o_sel_mux_1}), 32'(prev_sel));
      if (bus.o_dcod_en && !prev_en)
        chk("clr_before_en", 32'(prev_clr), 32'd1);
      prev_en      <= bus.o_dcod_en;
      prev_clr     <= bus.o_cnt_clr;
      prev_sel     <= {bus.o_sel_mux_0, bus.o_sel_mux_1};
      valid_pulses <= valid_pulses + int'(bus.o_resp_valid);
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while ((m_active || bus.o_busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("idle_timeout", 32'(n), 32'd0);
    #1;
  endtask

  task automatic run_challenge(input logic [3:0] seed, input int mode,
                               input int pulse_a, input int pulse_b, output int lat);
    int n;
    int v0;
    wait_idle();
    cur_mode        = mode;
    v0              = valid_pulses;
    bus.i_chal_seed = seed;
    bus.i_start     = 1'b1;
    @(posedge clk);
    #1;
    bus.i_start     = 1'b0;
    bus.i_chal_seed = 4'($urandom_range(0, 15));
    lat = -1;
    n = 0;
    while (n < 300 && lat < 0) begin
      @(negedge clk);
      n++;
      if (bus.o_resp_valid) lat = n;
      if (n == pulse_a || n == pulse_b) begin
        #1 bus.i_start = 1'b1;
      end else if (bus.i_start) begin
        #1 bus.i_start = 1'b0;
      end
    end
    if (bus.i_start) begin
      @(negedge clk);
      #1 bus.i_start = 1'b0;
    end
    chk("latency", 32'(lat), 32'(RUN_CYC));
    repeat (3) @(negedge clk);
    chk("valid_pulses", 32'(valid_pulses - v0), 32'd1);
  endtask

  initial begin
    int lat;
    int n;
    bus.i_start     = 1'b0;
    bus.i_chal_seed = '0;
    for (int i = 0; i < 16; i++) ro_val[i] = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'({bus.o_cnt_clr, bus.o_dcod_en, bus.o_sel_mux_0, bus.o_sel_mux_1,
                              bus.o_busy, bus.o_resp_valid, bus.o_tie_cnt}), 32'd0);
    chk("reset_resp", 32'(bus.o_resp), 32'd0);
    #1 rst = 1'b0;

    run_challenge(4'd0, 1, 0, 0, lat);
    chk("t1_resp", 32'(bus.o_resp), 32'h0FF);
    chk("t1_tie", 32'(bus.o_tie_cnt), 32'd0);

    run_challenge(4'd13, 2, 0, 0, lat);
    chk("t2_resp", 32'(bus.o_resp), 32'h0AA);
    chk("t2_tie", 32'(bus.o_tie_cnt), 32'd0);

    run_challenge(4'($urandom_range(0, 15)), 3, 0, 0, lat);
    chk("t3_resp", 32'(bus.o_resp), 32'd0);
    chk("t3_tie", 32'(bus.o_tie_cnt), 32'd2);

    run_challenge(4'($urandom_range(0, 15)), 1, 3 * PAIR_CYC + 4, RUN_CYC, lat);
    chk("t4_resp", 32'(bus.o_resp), 32'h0FF);
    for (int i = 0; i < 16; i++) ro_val[i] = 16'($urandom_range(0, 7));
    run_challenge(4'($urandom_range(0, 15)), 0, 0, 0, lat);

    wait_idle();
    cur_mode        = 1;
    bus.i_chal_seed = 4'($urandom_range(0, 15));
    bus.i_start     = 1'b1;
    @(posedge clk);
    #1 bus.i_start = 1'b0;
    n = 0;
    while (m_rel != 4 * PAIR_CYC + 5 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("rst_reach_eval", 32'(bus.o_dcod_en), 32'd1);
    chk("partial_resp", 32'(bus.o_resp), 32'h00F);
    #1 rst = 1'b1;
    #1;
    chk("rst_drop", 32'({bus.o_dcod_en, bus.o_busy, bus.o_resp}), 32'd0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    run_challenge(4'($urandom_range(0, 15)), 1, 0, 0, lat);
    chk("post_rst_resp", 32'(bus.o_resp), 32'h0FF);

    repeat (6) begin
      for (int i = 0; i < 16; i++) ro_val[i] = 16'($urandom_range(0, 7));
      run_challenge(4'($urandom_range(0, 15)), 0, 0, 0, lat);
    end

    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
